rsa_modexp_engine: RTL and testbench

Parametrised, constant-time modular exponentiation engine computing C = M^E mod P for arbitrary WIDTH, using left-to-right square-and-always-multiply over a bit-serial interleaved modular multiplier. It is the next-generation replacement for the fixed 8-bit RSA datapath behind the SPI/GPIO controller. It adds:
- operand latching at start;
- built-in M mod P pre-reduction (no precomputed constant register);
- abort;
- invalid-modulus error flag;
- sticky interrupt with explicit clear.

---
 rtl/rsa_modexp_engine.sv | 161 ++++++++++++++++
 tb/tb_rsa_modexp_engine.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/rsa_modexp_engine.sv
// Constant-time modular exponentiation C = M^E mod P.
// Uses left-to-right square-and-always-multiply over a bit-serial interleaved modular multiplier.
module rsa_modexp_engine #(
    parameter int unsigned WIDTH     = 8,
    parameter int unsigned EXP_WIDTH = WIDTH
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 ena,
    input  logic                 start,
    input  logic                 stop,
    input  logic [WIDTH-1:0]     P,
    input  logic [EXP_WIDTH-1:0] E,
    input  logic [WIDTH-1:0]     M,
    input  logic                 irq_clr,
    output logic                 busy,
    output logic                 done,
    output logic                 err,
    output logic                 irq,
    output logic [WIDTH-1:0]     C
);

    localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam int unsigned KW = (EXP_WIDTH > 1) ? $clog2(EXP_WIDTH) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);
    localparam logic [KW-1:0] K_FIRST  = KW'(EXP_WIDTH - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_REDUCE,
        S_SQR,
        S_MUL,
        S_DONE
    } state_t;

    state_t               r_state;
    logic [WIDTH-1:0]     r_p;
    logic [EXP_WIDTH-1:0] r_e;
    logic [WIDTH-1:0]     r_mr;
    logic [WIDTH-1:0]     r_r;
    logic [WIDTH-1:0]     r_acc;
    logic [WIDTH-1:0]     r_a;
    logic [WIDTH-1:0]     r_b;
    logic [CW-1:0]        r_cnt;
    logic [KW-1:0]        r_k;

    logic [WIDTH:0]       w_pe;
    logic [WIDTH:0]       w_t2;
    logic [WIDTH:0]       w_t1;
    logic [WIDTH:0]       w_t0;
    logic [WIDTH-1:0]     w_acc_next;
    logic [WIDTH-1:0]     w_r_mul;
    logic                 w_last;

    // One interleaved step: acc = (2*acc + a_msb*b) mod P, kept below P.
    always_comb begin
        w_pe       = {1'b0, r_p};
        w_t2       = {r_acc, 1'b0};
        w_t1       = (w_t2 >= w_pe) ? (w_t2 - w_pe) : w_t2;
        w_t0       = r_a[WIDTH-1] ? (w_t1 + {1'b0, r_b}) : w_t1;
        w_acc_next = (w_t0 >= w_pe) ? WIDTH'(w_t0 - w_pe) : WIDTH'(w_t0);
        w_r_mul    = r_e[EXP_WIDTH-1] ? w_acc_next : r_r;
        w_last     = (r_cnt == CNT_LAST);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_p     <= '0;
            r_e     <= '0;
            r_mr    <= '0;
            r_r     <= '0;
            r_acc   <= '0;
            r_a     <= '0;
            r_b     <= '0;
            r_cnt   <= '0;
            r_k     <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
            err     <= 1'b0;
            irq     <= 1'b0;
            C       <= '0;
        end else if (ena) begin
            done <= 1'b0;
            // Clear first so a completion in the same cycle re-sets irq.
            if (irq_clr)
                irq <= 1'b0;
            if (stop) begin
                if (r_state != S_IDLE) begin
                    r_state <= S_IDLE;
                    busy    <= 1'b0;
                end
            end else begin
                case (r_state)
                    S_IDLE: begin
                        if (start) begin
                            r_p <= P;
                            r_e <= E;
                            err <= 1'b0;
                            if (P <= WIDTH'(1)) begin
                                r_state <= S_DONE;
                                C       <= '0;
                                err     <= 1'b1;
                                done    <= 1'b1;
                                irq     <= 1'b1;
                            end else begin
                                r_state <= S_REDUCE;
                                busy    <= 1'b1;
                                r_r     <= WIDTH'(1);
                                r_k     <= K_FIRST;
                                r_a     <= M;
                                r_b     <= WIDTH'(1);
                                r_acc   <= '0;
                                r_cnt   <= '0;
                            end
                        end
                    end
                    S_REDUCE, S_SQR, S_MUL: begin
                        r_acc <= w_acc_next;
                        r_a   <= r_a << 1;
                        r_cnt <= r_cnt + CW'(1);
                        if (w_last) begin
                            r_acc <= '0;
                            r_cnt <= '0;
                            if (r_state == S_REDUCE) begin
                                r_mr    <= w_acc_next;
                                r_a     <= r_r;
                                r_b     <= r_r;
                                r_state <= S_SQR;
                            end else if (r_state == S_SQR) begin
                                r_r     <= w_acc_next;
                                r_a     <= w_acc_next;
                                r_b     <= r_mr;
                                r_state <= S_MUL;
                            end else begin
                                // Multiply result is always computed, kept only when E[k]=1.
                                r_r <= w_r_mul;
                                r_e <= r_e << 1;
                                if (r_k == '0) begin
                                    r_state <= S_DONE;
                                    busy    <= 1'b0;
                                    done    <= 1'b1;
                                    irq     <= 1'b1;
                                    C       <= w_r_mul;
                                end else begin
                                    r_k     <= r_k - KW'(1);
                                    r_a     <= w_r_mul;
                                    r_b     <= w_r_mul;
                                    r_state <= S_SQR;
                                end
                            end
                        end
                    end
                    S_DONE: r_state <= S_IDLE;
                    default: r_state <= S_IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_rsa_modexp_engine.sv
// Directed bench for rsa_modexp_engine: 8-bit instance for most scenarios, 16-bit instance for wide operands.
module tb_rsa_modexp_engine;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, ena, start, stop, irq_clr;
    logic [7:0]  P, E, M;
    logic        busy, done, err, irq;
    logic [7:0]  C;

    logic        start16;
    logic [15:0] P16, E16, M16;
    logic        busy16, done16, err16, irq16;
    logic [15:0] C16;

    int checks   = 0;
    int failures = 0;

    rsa_modexp_engine #(.WIDTH(8), .EXP_WIDTH(8)) dut8 (
        .clk(clk), .rst(rst), .ena(ena), .start(start), .stop(stop),
        .P(P), .E(E), .M(M), .irq_clr(irq_clr),
        .busy(busy), .done(done), .err(err), .irq(irq), .C(C)
    );

    rsa_modexp_engine #(.WIDTH(16), .EXP_WIDTH(16)) dut16 (
        .clk(clk), .rst(rst), .ena(ena), .start(start16), .stop(1'b0),
        .P(P16), .E(E16), .M(M16), .irq_clr(1'b0),
        .busy(busy16), .done(done16), .err(err16), .irq(irq16), .C(C16)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Start is sampled at the next edge (t); afterwards we sit in cycle t+1 with operands scrambled.
    task automatic launch(input logic [7:0] p, input logic [7:0] e, input logic [7:0] m);
        P = p; E = e; M = m; start = 1'b1;
        tick();
        start = 1'b0;
        P = 8'hA5; E = 8'h5A; M = 8'hFF;
    endtask

    // lat is the cycle index relative to the start edge in which done is seen; -1 on timeout.
    task automatic wait_done(input int n0, input int limit, output int lat);
        lat = n0;
        while (!done && lat < limit) begin
            tick();
            lat++;
        end
        if (!done) lat = -1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick(); tick();
        rst = 1'b0;
        checks++;
        if ({busy, done, err, irq, C} !== 12'h000) begin
            failures++;
            $display("FAIL reset_outputs got=%h exp=000", {busy, done, err, irq, C});
        end
    endtask

    task automatic test_basic();
        int lat;
        launch(8'd7, 8'd5, 8'd3);
        checks++;
        if (busy !== 1'b1) begin failures++; $display("FAIL basic_busy got=%b exp=1", busy); end
        wait_done(1, 300, lat);
        checks++;
        if (lat !== 137) begin failures++; $display("FAIL basic_latency got=%0d exp=137", lat); end
        checks++;
        if (C !== 8'd5) begin failures++; $display("FAIL basic_C got=%0d exp=5", C); end
        checks++;
        if ({irq, err, busy} !== 3'b100) begin failures++; $display("FAIL basic_flags got=%b exp=100", {irq, err, busy}); end
        tick();
        checks++;
        if (done !== 1'b0) begin failures++; $display("FAIL basic_done_pulse got=%b exp=0", done); end
        irq_clr = 1'b1;
        tick();
        irq_clr = 1'b0;
        checks++;
        if (irq !== 1'b0) begin failures++; $display("FAIL basic_irq_clr got=%b exp=0", irq); end
    endtask

    task automatic test_large_m();
        int lat;
        launch(8'd11, 8'd3, 8'd200);
        wait_done(1, 300, lat);
        checks++;
        if (lat !== 137) begin failures++; $display("FAIL largem_latency got=%0d exp=137", lat); end
        checks++;
        if (C !== 8'd8) begin failures++; $display("FAIL largem_C got=%0d exp=8", C); end
        tick();
        launch(8'd7, 8'd0, 8'd4);
        wait_done(1, 300, lat);
        checks++;
        if (lat !== 137) begin failures++; $display("FAIL e0_latency got=%0d exp=137", lat); end
        checks++;
        if (C !== 8'd1) begin failures++; $display("FAIL e0_C got=%0d exp=1", C); end
        tick();
    endtask

    task automatic test_error();
        int lat;
        launch(8'd1, 8'd5, 8'd3);
        wait_done(1, 5, lat);
        checks++;
        if (lat !== 1) begin failures++; $display("FAIL err_latency got=%0d exp=1", lat); end
        checks++;
        if ({err, irq, C} !== 10'b11_0000_0000) begin
            failures++; $display("FAIL err_flags got=%b exp=1100000000", {err, irq, C});
        end
        tick();
        launch(8'd7, 8'd5, 8'd3);
        checks++;
        if (err !== 1'b0) begin failures++; $display("FAIL err_clear got=%b exp=0", err); end
        wait_done(1, 300, lat);
        checks++;
        if (C !== 8'd5 || err !== 1'b0) begin failures++; $display("FAIL err_recover got C=%0d err=%b exp C=5 err=0", C, err); end
        tick();
    endtask

    task automatic test_stop();
        int lat;
        int ndone;
        launch(8'd11, 8'd3, 8'd200);
        repeat (49) tick();
        stop = 1'b1;
        tick();
        stop = 1'b0;
        checks++;
        if (busy !== 1'b0 || C !== 8'd5) begin failures++; $display("FAIL stop_mid got busy=%b C=%0d exp busy=0 C=5", busy, C); end
        ndone = 0;
        repeat (150) begin tick(); if (done) ndone++; end
        checks++;
        if (ndone !== 0 || C !== 8'd5) begin failures++; $display("FAIL stop_no_done got dones=%0d C=%0d exp 0/5", ndone, C); end
        P = 8'd11; E = 8'd3; M = 8'd200; start = 1'b1; stop = 1'b1;
        tick();
        start = 1'b0; stop = 1'b0;
        checks++;
        if (busy !== 1'b0) begin failures++; $display("FAIL stop_start_same got busy=%b exp=0", busy); end
        ndone = 0;
        repeat (150) begin tick(); if (done) ndone++; end
        checks++;
        if (ndone !== 0 || C !== 8'd5) begin failures++; $display("FAIL stop_start_no_done got dones=%0d C=%0d exp 0/5", ndone, C); end
        launch(8'd11, 8'd3, 8'd200);
        repeat (29) tick();
        P = 8'd7; E = 8'd5; M = 8'd3; start = 1'b1;
        tick();
        start = 1'b0;
        wait_done(31, 300, lat);
        checks++;
        if (lat !== 137 || C !== 8'd8) begin failures++; $display("FAIL start_while_busy got lat=%0d C=%0d exp 137/8", lat, C); end
        tick();
    endtask

    task automatic test_ena();
        int lat;
        launch(8'd7, 8'd5, 8'd3);
        repeat (19) tick();
        ena = 1'b0;
        repeat (10) tick();
        ena = 1'b1;
        wait_done(30, 400, lat);
        checks++;
        if (lat !== 147) begin failures++; $display("FAIL ena_latency got=%0d exp=147", lat); end
        checks++;
        if (C !== 8'd5) begin failures++; $display("FAIL ena_C got=%0d exp=5", C); end
        tick();
    endtask

    task automatic test_irq_priority();
        int lat;
        irq_clr = 1'b1;
        launch(8'd11, 8'd3, 8'd200);
        wait_done(1, 300, lat);
        checks++;
        if (irq !== 1'b1 || C !== 8'd8) begin failures++; $display("FAIL irq_set_wins got irq=%b C=%0d exp 1/8", irq, C); end
        tick();
        irq_clr = 1'b0;
        checks++;
        if (irq !== 1'b0) begin failures++; $display("FAIL irq_clr_after got=%b exp=0", irq); end
    endtask

    task automatic test_rst_mid();
        int ndone;
        launch(8'd7, 8'd5, 8'd3);
        repeat (40) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checks++;
        if ({busy, done, err, irq, C} !== 12'h000) begin
            failures++; $display("FAIL rst_mid got=%h exp=000", {busy, done, err, irq, C});
        end
        ndone = 0;
        repeat (150) begin tick(); if (done) ndone++; end
        checks++;
        if (ndone !== 0) begin failures++; $display("FAIL rst_mid_no_done got=%0d exp=0", ndone); end
    endtask

    task automatic test_w16();
        int lat;
        P16 = 16'd65521; E16 = 16'd16; M16 = 16'd2; start16 = 1'b1;
        tick();
        start16 = 1'b0;
        P16 = 16'hFFFF; E16 = 16'h1234; M16 = 16'h0077;
        lat = 1;
        while (!done16 && lat < 800) begin tick(); lat++; end
        if (!done16) lat = -1;
        checks++;
        if (lat !== 529) begin failures++; $display("FAIL w16_latency got=%0d exp=529", lat); end
        checks++;
        if (C16 !== 16'd15 || err16 !== 1'b0 || irq16 !== 1'b1) begin
            failures++; $display("FAIL w16_result got C=%0d err=%b irq=%b exp 15/0/1", C16, err16, irq16);
        end
        tick();
    endtask

    initial begin
        rst = 1'b1; ena = 1'b1; start = 1'b0; stop = 1'b0; irq_clr = 1'b0;
        P = '0; E = '0; M = '0;
        start16 = 1'b0; P16 = '0; E16 = '0; M16 = '0;
        #1;
        test_reset();
        test_basic();
        test_large_m();
        test_error();
        test_stop();
        test_ena();
        test_irq_priority();
        test_rst_mid();
        test_w16();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
